matmul_seq_ctrl: RTL
====================

// Module: matmul_seq_ctrl
// PURPOSE
//  Sequencer for the complex matrix-multiply datapath (dual-port ROMs M1/M2 -> prodtwo -> sumtwo).
//  Computes C = A x B for NxN complex matrices by issuing ROM read addresses for every (i,j,k) term.
//  Emits a tagged control pipeline aligned to the datapath: accumulate-clear/enable, then result write.
//  Sits between the system start/done handshake and the ROM, accumulator and result-SPRAM controls.
// PARAMETERS
//  N        2  matrix dimension; requires 2*N*N <= 2**NDIR
//  NDIR     4  ROM address width
//  RDIR     2  result RAM address width; requires N*N <= 2**RDIR
//  PIPE_LAT 3  cycles from address issue to valid ab_real/ab_imag (ROM 1 + prodtwo 1 + sumtwo 1)
// PORTS
//  clk      in   1     system clock, rising edge
//  rst      in   1     asynchronous, active-low reset
//  start    in   1     request a full multiply; sampled only in IDLE
//  busy     out  1     high from the cycle after start is accepted until done
//  done     out  1     one-cycle pulse when the last result has been written
//  addr_am1 out  NDIR  ROM M1 port a: Re A[i][k]
//  addr_bm1 out  NDIR  ROM M1 port b: Im A[i][k]
//  addr_am2 out  NDIR  ROM M2 port a: Re B[k][j]
//  addr_bm2 out  NDIR  ROM M2 port b: Im B[k][j]
//  acc_en   out  1     datapath term valid this cycle; accumulate it
//  acc_clr  out  1     with acc_en: load the term instead of adding (k==0)
//  we       out  1     write the accumulated C[i][j] into the result RAMs
//  addr_wr  out  RDIR  result address i*N+j, valid while we=1
// BEHAVIOUR
//  - Reset (rst=0, async): FSM=IDLE, all outputs 0, tag pipeline cleared; in-flight terms discarded, no we.
//  - Memory map: element m[r][c] real at 2*(r*N+c), imag at 2*(r*N+c)+1, in both ROMs.
//  - FSM IDLE: start=1 at edge t0 -> ISSUE; start is ignored in every other state.
//  - ISSUE: one (i,j,k) term per cycle, k fastest, then j, then i; N**3 cycles total.
//    Address outputs are registered and update at each edge; in IDLE/DRAIN they hold 0.
//  - After issue (0,0,0) through (N-1,N-1,N-1) -> DRAIN.
//  - DRAIN: wait until the tag pipeline is empty -> DONE.
//  - DONE: done=1 and busy=0 for one cycle -> IDLE. busy=1 during ISSUE and DRAIN only.
//  - Tag pipeline: {valid, first=(k==0), last=(k==N-1), waddr} delayed PIPE_LAT cycles.
//    At stage PIPE_LAT: acc_en=valid, acc_clr=valid&first.
//    At stage PIPE_LAT+1: we=valid&last, addr_wr=waddr; the accumulator value is registered one cycle.
//  - Timing, term issued in cycle t: acc_en in cycle t+PIPE_LAT; on a last term, we in cycle t+PIPE_LAT+1.
//  - Index counters are $clog2(N) bits wide. Wrap k->0 with j++, j->0 with i++; terminal when i,j,k all = N-1.
//  - Address arithmetic: unsigned, computed in NDIR bits; no overflow when the parameter constraints hold.
//  - start held high continuously: exactly one multiply per IDLE visit; restart at the earliest one cycle after done.
// CONFIGURATION
//  MATMUL_TRANSPOSE_B_EN defined:
//    - adds input port transpose_b (1 bit), latched when start is accepted and constant for the whole run.
//    - transpose_b=1 reads B[j][k] instead of B[k][j] (C = A x B^T); transpose_b=0 gives the normal product.
//  MATMUL_TRANSPOSE_B_EN undefined: the port does not exist and B is always read as B[k][j].
// TESTING
//  1. rst=0 pulse mid-ISSUE (cycle 5, N=2) -> all outputs 0 asynchronously.
//     No we afterwards; FSM in IDLE. Next start runs a full clean sequence.
//  2. N=2, PIPE_LAT=3, start at edge 0:
//     - issue cycles 1..8; acc_en cycles 4..11; acc_clr in cycles 4,6,8,10.
//     - we in cycles 6,8,10,12 with addr_wr 0,1,2,3.
//     - done in cycle 13, busy high in cycles 1..12.
//  3. Issue cycle 4 (i=0,j=1,k=1) -> addr_am1=2, addr_bm1=3, addr_am2=6, addr_bm2=7.
//  4. start held high for 40 cycles -> two complete runs. done in cycles 13 and 27; no overlap, no skipped term.
//  5. Datapath model with A=identity, B entries (1+2i),(3-1i),(0.5+0i),(-2+4i) -> SPRAM holds exactly B.
//     Real and imaginary parts checked at addresses 0..3.
//  6. MATMUL_TRANSPOSE_B_EN, transpose_b=1, same B as test 5 -> SPRAM holds B^T.
//     Addresses 1 and 2 swapped vs. test 5. Toggling transpose_b mid-run has no effect.

Source files
------------

// File: rtl/matmul_seq_ctrl.sv
// matmul_seq_ctrl
//   Sequencer for the complex matrix-multiply datapath
//   (dual-port ROMs M1/M2 -> prodtwo -> sumtwo). Walks every (i,j,k) term of
//   C = A x B, issuing ROM read addresses one term per cycle (k fastest), and
//   emits a tag pipeline aligned to the datapath latency that drives the
//   accumulator (acc_en/acc_clr) and the result-RAM write (we/addr_wr).
//
//   Ports
//     clk          system clock, rising edge
//     rst          asynchronous, active-low reset
//     start        request a full multiply (only looked at in IDLE)
//     transpose_b  (MATMUL_TRANSPOSE_B_EN only) read B[j][k] instead of B[k][j]
//     busy         high while issuing and draining
//     done         one-cycle pulse after the last result write
//     addr_am1/bm1 ROM M1 real/imag address of A[i][k]
//     addr_am2/bm2 ROM M2 real/imag address of B[k][j] (or B[j][k])
//     acc_en       datapath term valid this cycle
//     acc_clr      with acc_en: load instead of add (k==0)
//     we, addr_wr  write accumulated C[i][j] to result address i*N+j
//
//   Optional feature macro: MATMUL_TRANSPOSE_B_EN
//     When defined, adds transpose_b, latched when start is accepted.
module matmul_seq_ctrl #(
  parameter int N        = 2,
  parameter int NDIR     = 4,
  parameter int RDIR     = 2,
  parameter int PIPE_LAT = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
`ifdef MATMUL_TRANSPOSE_B_EN
  input  logic            transpose_b,
`endif
  output logic            busy,
  output logic            done,
  output logic [NDIR-1:0] addr_am1,
  output logic [NDIR-1:0] addr_bm1,
  output logic [NDIR-1:0] addr_am2,
  output logic [NDIR-1:0] addr_bm2,
  output logic            acc_en,
  output logic            acc_clr,
  output logic            we,
  output logic [RDIR-1:0] addr_wr
);

  localparam int            CW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] IX_LST = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t        state, nxt_state;
  logic [CW-1:0] i_q, j_q, k_q;
  logic [CW-1:0] nxt_i, nxt_j, nxt_k;
  logic          tr_eff;

  // Tag pipeline: stage s holds the tag of the term issued s cycles ago.
  logic [PIPE_LAT+1:1]           vld_pipe;
  logic [PIPE_LAT:1]             first_pipe;
  logic [PIPE_LAT+1:1]           last_pipe;
  logic [PIPE_LAT+1:1][RDIR-1:0] wa_pipe;

  logic            issue, issue_first, issue_last;
  logic [RDIR-1:0] issue_wa;
  logic [NDIR-1:0] a_idx, b_idx;

  // ---------------- FSM + index counters ----------------
  always_comb begin
    nxt_state = state;
    nxt_i     = i_q;
    nxt_j     = j_q;
    nxt_k     = k_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          nxt_state = S_ISSUE;
          nxt_i     = '0;
          nxt_j     = '0;
          nxt_k     = '0;
        end
      end
      S_ISSUE: begin
        if (k_q == IX_LST) begin
          nxt_k = '0;
          if (j_q == IX_LST) begin
            nxt_j = '0;
            if (i_q == IX_LST) nxt_state = S_DRAIN;
            else               nxt_i     = i_q + 1'b1;
          end else begin
            nxt_j = j_q + 1'b1;
          end
        end else begin
          nxt_k = k_q + 1'b1;
        end
      end
      // Stage PIPE_LAT+1 leaves on this edge; once stages 1..PIPE_LAT are
      // empty the pipeline is empty in the next cycle.
      S_DRAIN: if (~|vld_pipe[PIPE_LAT:1]) nxt_state = S_DONE;
      S_DONE:  nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      i_q   <= '0;
      j_q   <= '0;
      k_q   <= '0;
    end else begin
      state <= nxt_state;
      i_q   <= nxt_i;
      j_q   <= nxt_j;
      k_q   <= nxt_k;
    end
  end

  // ---------------- transpose select ----------------
`ifdef MATMUL_TRANSPOSE_B_EN
  logic tr_q;
  // The first term's addresses are registered on the accept edge, before
  // tr_q updates, so take the live input while still in IDLE.
  assign tr_eff = (state == S_IDLE) ? transpose_b : tr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        tr_q <= 1'b0;
    else if (state == S_IDLE && start) tr_q <= transpose_b;
  end
`else
  assign tr_eff = 1'b0;
`endif

  // ---------------- ROM addresses ----------------
  // Registered from the next-state counters so the address of a term is on
  // the ROM pins during the cycle that term is issued.
  always_comb begin
    a_idx = NDIR'(nxt_i) * NDIR'(N) + NDIR'(nxt_k);
    if (tr_eff) b_idx = NDIR'(nxt_j) * NDIR'(N) + NDIR'(nxt_k);
    else        b_idx = NDIR'(nxt_k) * NDIR'(N) + NDIR'(nxt_j);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_am1 <= '0;
      addr_bm1 <= '0;
      addr_am2 <= '0;
      addr_bm2 <= '0;
    end else if (nxt_state == S_ISSUE) begin
      addr_am1 <= a_idx << 1;
      addr_bm1 <= (a_idx << 1) | NDIR'(1);
      addr_am2 <= b_idx << 1;
      addr_bm2 <= (b_idx << 1) | NDIR'(1);
    end else begin
      addr_am1 <= '0;
      addr_bm1 <= '0;
      addr_am2 <= '0;
      addr_bm2 <= '0;
    end
  end

  // ---------------- tag pipeline ----------------
  assign issue       = (state == S_ISSUE);
  assign issue_first = (k_q == '0);
  assign issue_last  = (k_q == IX_LST);
  assign issue_wa    = RDIR'(i_q) * RDIR'(N) + RDIR'(j_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe   <= '0;
      first_pipe <= '0;
      last_pipe  <= '0;
      wa_pipe    <= '0;
    end else begin
      vld_pipe   <= {vld_pipe[PIPE_LAT:1], issue};
      first_pipe <= {first_pipe[PIPE_LAT-1:1], issue_first};
      last_pipe  <= {last_pipe[PIPE_LAT:1], issue_last};
      wa_pipe    <= {wa_pipe[PIPE_LAT:1], issue_wa};
    end
  end

  // ---------------- outputs ----------------
  assign acc_en  = vld_pipe[PIPE_LAT];
  assign acc_clr = vld_pipe[PIPE_LAT] & first_pipe[PIPE_LAT];
  // One extra stage: the accumulator registers the last term's sum first.
  assign we      = vld_pipe[PIPE_LAT+1] & last_pipe[PIPE_LAT+1];
  assign addr_wr = wa_pipe[PIPE_LAT+1];
  assign busy    = (state == S_ISSUE) || (state == S_DRAIN);
  assign done    = (state == S_DONE);

endmodule
